// File: rtl/tl45_icache_pfetch_if.sv
// rtl/tl45_icache_pfetch_if.sv - pipelined Wishbone read bus between the prefetch unit and memory
interface tl45_icache_pfetch_if #(
    parameter int AW = 30
);
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_ack;
    logic          i_wb_stall;
    logic          i_wb_err;
    logic [31:0]   i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/tl45_icache_pfetch.sv
// rtl/tl45_icache_pfetch.sv - instruction prefetch unit with direct-mapped cache and pipelined line fill
module tl45_icache_pfetch #(
    parameter int AW         = 30,
    parameter int LINE_WORDS = 16,
    parameter int NUM_LINES  = 256
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_pipe_stall,
    input  logic                i_pipe_flush,
    input  logic                i_new_pc,
    input  logic [31:0]         i_pc,
    input  logic                i_invalidate,
    tl45_icache_pfetch_if.master wb,
    output logic                o_buf_valid,
    output logic                o_buf_err,
    output logic [31:0]         o_buf_pc,
    output logic [31:0]         o_buf_inst
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = AW - OW - IW;
    localparam int CW = OW + 1;
    localparam logic [CW-1:0] LW_C = CW'(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ERR} state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [NUM_LINES-1:0] r_valid;
    logic [TW-1:0]        r_tag_ram  [NUM_LINES];
    logic [31:0]          r_data_ram [NUM_LINES*LINE_WORDS];
    logic                 r_cyc;
    logic                 r_stb;
    logic                 r_poison;
    logic                 r_err_pend;
    logic [AW-1:0]        r_wb_addr;
    logic [AW-OW-1:0]     r_fill_line;
    logic [CW-1:0]        r_issued;
    logic [CW-1:0]        r_acked;
    logic                 r_buf_valid;
    logic                 r_buf_err;
    logic [31:0]          r_buf_pc;
    logic [31:0]          r_buf_inst;

    logic [AW-1:0]        w_word;
    logic [TW-1:0]        w_tag;
    logic [IW-1:0]        w_index;
    logic [OW+IW-1:0]     w_line_word;
    logic                 w_hit;
    logic [31:0]          w_inst;
    logic [IW-1:0]        w_fill_index;
    logic [TW-1:0]        w_fill_tag;
    logic [OW+IW-1:0]     w_fill_slot;
    logic                 w_accept;
    logic                 w_ack;
    logic                 w_done;
    logic                 w_unused;

    assign w_word       = r_pc[AW+1:2];
    assign w_tag        = w_word[AW-1:OW+IW];
    assign w_index      = w_word[OW+IW-1:OW];
    assign w_line_word  = w_word[OW+IW-1:0];
    assign w_hit        = r_valid[w_index] && (r_tag_ram[w_index] == w_tag);
    assign w_inst       = r_data_ram[w_line_word];
    assign w_fill_index = r_fill_line[IW-1:0];
    assign w_fill_tag   = r_fill_line[AW-OW-1:IW];
    assign w_fill_slot  = {w_fill_index, r_acked[OW-1:0]};
    assign w_accept     = r_stb && !wb.i_wb_stall;
    assign w_ack        = (r_state == S_FILL) && wb.i_wb_ack;
    assign w_done       = w_ack && (r_acked == LW_C - 1'b1);
    assign w_unused     = ^{i_pc[1:0], r_pc[1:0]};

    assign wb.o_wb_cyc  = r_cyc;
    assign wb.o_wb_stb  = r_stb;
    assign wb.o_wb_we   = 1'b0;
    assign wb.o_wb_addr = r_wb_addr;
    assign wb.o_wb_data = 32'd0;
    assign wb.o_wb_sel  = 4'hF;

    assign o_buf_valid  = r_buf_valid;
    assign o_buf_err    = r_buf_err;
    assign o_buf_pc     = r_buf_pc;
    assign o_buf_inst   = r_buf_inst;

    // Line storage: acked words land in order, tag written with the final word.
    always_ff @(posedge i_clk) begin
        if (w_ack) begin
            r_data_ram[w_fill_slot] <= wb.i_wb_data;
        end
        if (w_done) begin
            r_tag_ram[w_fill_index] <= w_fill_tag;
        end
    end

    // Fetch control: valid vector, PC, decode buffer and the line-fill bus FSM.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_pc        <= 32'd0;
            r_valid     <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_poison    <= 1'b0;
            r_err_pend  <= 1'b0;
            r_wb_addr   <= '0;
            r_fill_line <= '0;
            r_issued    <= '0;
            r_acked     <= '0;
            r_buf_valid <= 1'b0;
            r_buf_err   <= 1'b0;
            r_buf_pc    <= 32'd0;
            r_buf_inst  <= 32'd0;
        end else begin
            // A same-cycle invalidate wins over installing a completed line.
            if (i_invalidate) begin
                r_valid <= '0;
            end else if (w_done && !r_poison) begin
                r_valid[w_fill_index] <= 1'b1;
            end

            if (i_new_pc || i_pipe_flush) begin
                r_buf_valid <= 1'b0;
                r_buf_err   <= 1'b0;
                r_buf_pc    <= 32'd0;
                r_buf_inst  <= 32'd0;
                if (i_new_pc) begin
                    r_pc <= {i_pc[31:2], 2'b00};
                end
            end else if (i_pipe_stall) begin
                r_buf_valid <= r_buf_valid;
            end else if (r_state == S_ERR && r_err_pend) begin
                r_buf_valid <= 1'b1;
                r_buf_err   <= 1'b1;
                r_buf_pc    <= r_pc;
                r_buf_inst  <= 32'd0;
                r_err_pend  <= 1'b0;
            end else if (r_state == S_IDLE && w_hit && !i_invalidate) begin
                r_buf_valid <= 1'b1;
                r_buf_err   <= 1'b0;
                r_buf_pc    <= r_pc;
                r_buf_inst  <= w_inst;
                r_pc        <= r_pc + 32'd4;
            end else begin
                r_buf_valid <= 1'b0;
                r_buf_err   <= 1'b0;
                r_buf_pc    <= 32'd0;
                r_buf_inst  <= 32'd0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!i_new_pc && !i_pipe_flush && !i_invalidate && !w_hit) begin
                        r_fill_line <= {w_tag, w_index};
                        r_wb_addr   <= {w_tag, w_index, {OW{1'b0}}};
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_issued    <= '0;
                        r_acked     <= '0;
                        r_poison    <= 1'b0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_invalidate) begin
                        r_poison <= 1'b1;
                    end
                    if (w_accept) begin
                        r_wb_addr <= r_wb_addr + 1'b1;
                        r_issued  <= r_issued + 1'b1;
                        if (r_issued == LW_C - 1'b1) begin
                            r_stb <= 1'b0;
                        end
                    end
                    if (wb.i_wb_err) begin
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_err_pend <= 1'b1;
                        r_state    <= S_ERR;
                    end else if (w_ack) begin
                        r_acked <= r_acked + 1'b1;
                        if (w_done) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ERR: begin
                    if (i_new_pc) begin
                        r_err_pend <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/tl45_icache_pfetch.md
Name: tl45_icache_pfetch

Overview:
- Parametrised instruction prefetch unit with a direct-mapped instruction cache, for the tl45 core front end.
- It sits between the PC-redirect logic and the decode buffer, and masters a pipelined Wishbone bus for line fills.
- Compared with the first-generation fetch unit, it adds configurable line and cache geometry.
- Fills issue back-to-back strobes instead of one request per ack.
- It adds a whole-cache invalidate input, and bus errors are reported to the pipeline instead of silently retried.

Parameters:
- AW, 30: word address width; PC is {addr, 2'b00}, so only PC[AW+1:2] is used.
- LINE_WORDS, 16: words per cache line; power of two, 2..64.
- NUM_LINES, 256: number of cache lines; power of two, 4..1024.
- Derived widths (not parameters):
  - OW = log2(LINE_WORDS)
  - IW = log2(NUM_LINES)
  - TW = AW-OW-IW

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_pipe_stall  in  1  decode not ready; hold o_buf_*.
- i_pipe_flush  in  1  clear the buffer; keep the PC.
- i_new_pc  in  1  redirect: load i_pc and clear the buffer.
- i_pc  in  32  redirect target; bits [1:0] ignored.
- i_invalidate  in  1  one-cycle pulse that invalidates every line.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  request strobe.
- o_wb_we  out  1  tied 0.
- o_wb_addr  out  AW  request word address.
- o_wb_data  out  32  tied 0.
- o_wb_sel  out  4  tied 4'hF.
- i_wb_ack  in  1  data valid.
- i_wb_stall  in  1  request not accepted this cycle.
- i_wb_err  in  1  bus error, in place of ack.
- i_wb_data  in  32  read data.
- o_buf_valid  out  1  buffer holds an instruction or an error.
- o_buf_err  out  1  the fetch at o_buf_pc faulted.
- o_buf_pc  out  32  PC of the buffered word.
- o_buf_inst  out  32  instruction word; 0 when not valid or on error.

Behaviour:
- Reset (async assert, sync release):
  - All o_buf_* = 0; PC = 0; state = IDLE.
  - o_wb_cyc = o_wb_stb = 0; o_wb_addr = 0.
  - Valid vector (a NUM_LINES-bit register) cleared.
  - Tag and data RAMs are not reset.
- Address split of the PC word address: tag = [AW-1:OW+IW], index = [OW+IW-1:OW], offset = [OW-1:0].
- Hit = valid[index] && tag_ram[index] == tag. Arrays are read asynchronously.
- Buffer update priority: reset > (i_new_pc | i_pipe_flush) > i_pipe_stall > normal.
  - Redirect or flush: o_buf_valid = 0, pc/inst = 0. On i_new_pc, PC <= i_pc.
  - Stall: hold all o_buf_*.
  - Normal, state IDLE and hit: next cycle o_buf_valid = 1, inst = data, pc = PC; PC += 4. Hit-to-buffer latency is 1 cycle, sustaining 1 word per cycle.
  - Normal, not a hit: o_buf_valid = 0.
- States:
  - IDLE: on a miss (not redirect, not invalidate that cycle), latch the line base {tag, index, 0} into a fill register, then go to FILL.
  - FILL: o_wb_cyc = 1.
    - o_wb_stb = 1 while issued < LINE_WORDS.
    - A request is accepted when stb && !stall; then o_wb_addr increments and issued increments.
    - Each ack writes data_ram[index][acked] and increments acked.
    - When acked reaches LINE_WORDS: write the tag, set valid unless the line is poisoned, drop cyc, return to IDLE. The next cycle can hit.
    - Fill latency with a zero-wait slave is LINE_WORDS+1 cycles from the miss to cyc dropping.
  - ERR: entered on i_wb_err in FILL.
    - Drop cyc/stb the same edge; the line stays invalid.
    - When not stalled and not redirected: o_buf_valid = 1, o_buf_err = 1, pc = PC, inst = 0.
    - Then hold in ERR with o_buf_valid = 0 until i_new_pc, which returns to IDLE.
    - Flush alone does not leave ERR.
- i_new_pc or flush during FILL: the fill runs to completion and the line is installed. The new PC is evaluated in IDLE afterwards.
- i_invalidate:
  - Clears the whole valid vector at the next edge.
  - If in FILL, the current line is poisoned: it completes on the bus but valid is not set.
  - A hit in the same cycle as i_invalidate is suppressed (the buffer gets o_buf_valid = 0).
- Simultaneous invalidate and fill completion: valid stays 0.
- Bus rules:
  - No stb without cyc.
  - cyc stays asserted until all issued requests are acked, or an err occurs.
  - Acks arriving outside FILL are ignored.
- PC wraps modulo 2^32; the tag compare uses only PC[AW+1:2].

Test Plan:
- Cold miss with LINE_WORDS=16 and a zero-wait slave; i_new_pc to 0x100 → 16 strobes on consecutive cycles, addresses 0x40..0x4F. Then o_buf_pc 0x100, 0x104, … on consecutive cycles with the correct data.
- Slave asserts i_wb_stall on alternate cycles during the fill → o_wb_addr holds while stalled; exactly 16 accepted requests and 16 writes; cyc drops after the 16th ack.
- i_wb_err on the 5th ack for PC 0x200 → cyc drops the same edge. One cycle later: o_buf_valid=1, o_buf_err=1, o_buf_pc=0x200. No further requests until i_new_pc=0x300, which starts a new fill.
- Cached loop at 0x100..0x13C, then i_invalidate → the next access misses and refills. i_invalidate mid-fill → that line misses again after completion.
- i_pipe_stall held 3 cycles while hitting → o_buf_* unchanged and PC frozen. i_new_pc during a fill → the fill completes, then fetch resumes at the new PC.
- Assert i_reset_n=0 asynchronously mid-fill → cyc, stb and o_buf_valid go 0 immediately. After release, PC 0 misses.
